// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the multi-cycle multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      MD_DIV   = 3'd0,
      MD_DIVU  = 3'd1,
      MD_MULT  = 3'd2,
      MD_MULTU = 3'd3,
      MD_MADD  = 3'd4,
      MD_MADDU = 3'd5,
      MD_MSUB  = 3'd6,
      MD_MSUBU = 3'd7
   } md_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DIV  = 3'd1,
      S_MUL  = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } md_state_e;

   // Replicated across LO when the divisor is zero.
   localparam logic DIV_ZERO_FILL = 1'b1;

   // Even op codes are the signed flavours.
   function automatic logic op_signed(input logic [OP_W-1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [OP_W-1:0] op);
      return (op[2:1] == 2'b00);
   endfunction

   function automatic logic op_is_acc(input logic [OP_W-1:0] op);
      return op[2];
   endfunction

   function automatic logic op_is_sub(input logic [OP_W-1:0] op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep if non-negative.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic [WIDTH-1:0] quo_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // quo_i doubles as the dividend shift register; its MSB is the next dividend bit.
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      diff    = shifted - {1'b0, divisor_i};
      if (!diff[WIDTH]) begin
         rem_o = diff[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit writing HI/LO beside the EX-stage ALU.
// Define MULDIV_MADD_EN to build the multiply-accumulate/subtract path (ACC state, hilo_i adder).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [OP_W-1:0]    op_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   input  logic [2*WIDTH-1:0] hilo_i,
   input  logic               cancel_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o,
   output logic               div_zero_o
);

   localparam int unsigned DW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   md_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;

   logic             sgn, opa_neg, opb_neg;
   logic [WIDTH-1:0] opa_mag, opb_mag;
   logic [WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix;
   logic [DW-1:0]    prod_mag, prod;

`ifdef MULDIV_MADD_EN
   logic          acc_q, acc_d;
   logic          sub_q, sub_d;
   logic [DW-1:0] prod_q, prod_d;
   logic [DW-1:0] acc_res;
`else
   logic unused_hilo;
   assign unused_hilo = ^hilo_i;
`endif

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
      return en ? (~x + WIDTH'(1)) : x;
   endfunction

   function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] x, input logic en);
      return en ? (~x + DW'(1)) : x;
   endfunction

   // Magnitude conversion shared by the divide and multiply paths.
   always_comb begin
      sgn     = op_signed(op_i);
      opa_neg = sgn & opa_i[WIDTH-1];
      opb_neg = sgn & opb_i[WIDTH-1];
      opa_mag = neg_w(opa_i, opa_neg);
      opb_mag = neg_w(opb_i, opb_neg);
   end

   assign prod_mag = DW'(a_q) * DW'(b_q);
   assign prod     = neg_dw(prod_mag, neg_q);

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i     (rem_q),
      .divisor_i (b_q),
      .quo_i     (a_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // Signed fix-up applied to the final step on the way into DONE.
   assign quo_fix = neg_w(step_quo, neg_q);
   assign rem_fix = neg_w(step_rem, rneg_q);

`ifdef MULDIV_MADD_EN
   assign acc_res = sub_q ? (hilo_i - prod_q) : (hilo_i + prod_q);
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      hi_d    = '0;
      lo_d    = '0;
      dz_d    = 1'b0;
      done_d  = 1'b0;
      busy_o  = 1'b0;
`ifdef MULDIV_MADD_EN
      acc_d   = acc_q;
      sub_d   = sub_q;
      prod_d  = prod_q;
`endif

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_i) begin
               busy_o = 1'b1;
               a_d    = opa_mag;
               b_d    = opb_mag;
               rem_d  = '0;
               neg_d  = opa_neg ^ opb_neg;
               rneg_d = opa_neg;
`ifdef MULDIV_MADD_EN
               acc_d  = op_is_acc(op_i);
               sub_d  = op_is_sub(op_i);
`endif
               if (!op_is_div(op_i)) begin
                  state_d = S_MUL;
               end else if (opb_i == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  dz_d    = 1'b1;
                  lo_d    = {WIDTH{DIV_ZERO_FILL}};
                  hi_d    = opa_i;
               end else begin
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            busy_o = 1'b1;
            a_d    = step_quo;
            rem_d  = step_rem;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               lo_d    = quo_fix;
               hi_d    = rem_fix;
            end
         end
         S_MUL: begin
            busy_o = 1'b1;
`ifdef MULDIV_MADD_EN
            if (acc_q) begin
               prod_d  = prod;
               state_d = S_ACC;
            end else begin
               state_d      = S_DONE;
               done_d       = 1'b1;
               {hi_d, lo_d} = prod;
            end
`else
            state_d      = S_DONE;
            done_d       = 1'b1;
            {hi_d, lo_d} = prod;
`endif
         end
`ifdef MULDIV_MADD_EN
         S_ACC: begin
            busy_o       = 1'b1;
            state_d      = S_DONE;
            done_d       = 1'b1;
            {hi_d, lo_d} = acc_res;
         end
`endif
         S_DONE: begin
            // Hold the single write until EX releases the instruction.
            if (start_i) begin
               done_d = 1'b1;
               hi_d   = hi_q;
               lo_d   = lo_q;
               dz_d   = dz_q;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (cancel_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         busy_o  = 1'b0;
         done_d  = 1'b0;
         hi_d    = '0;
         lo_d    = '0;
         dz_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
         acc_q   <= 1'b0;
         sub_q   <= 1'b0;
         prod_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
`ifdef MULDIV_MADD_EN
         acc_q   <= acc_d;
         sub_q   <= sub_d;
         prod_q  <= prod_d;
`endif
      end
   end

   assign done_o     = done_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign div_zero_o = dz_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit that sits beside the execute-stage ALU and owns every operation writing HI/LO that cannot finish in one cycle. It handles signed and unsigned divide (restoring, one quotient bit per cycle), registered multiply and, optionally, multiply-accumulate/subtract against the forwarded HI:LO value. While an operation is in flight it stalls the pipeline. It returns a HI/LO write that the execute stage muxes onto its existing hi/lo/whilo outputs.

## Interface
- WIDTH, 32, operand width; even, at least 8; HI/LO are each WIDTH bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  request; held high by execute stage while the instruction sits in EX
- op_i  in  3  operation: DIV, DIVU, MULT, MULTU, MADD, MADDU, MSUB, MSUBU
- opa_i  in  WIDTH  rs operand (dividend / multiplicand)
- opb_i  in  WIDTH  rt operand (divisor / multiplier)
- hilo_i  in  2*WIDTH  forwarded {HI,LO}, used by accumulate ops only
- cancel_i  in  1  flush/annul of the instruction in EX
- busy_o  out  1  stall request to pipeline control
- done_o  out  1  result valid, doubles as whilo
- hi_o  out  WIDTH  result for HI (remainder / product high half)
- lo_o  out  WIDTH  result for LO (quotient / product low half)
- div_zero_o  out  1  qualifies done_o: divisor was zero

## Operation
- States: IDLE, DIV, MUL, ACC, DONE.
- IDLE: if start_i & !cancel_i, capture op_i/opa_i/opb_i and branch:
  - divide with opb_i==0 -> DONE
  - divide otherwise -> DIV
  - multiply or accumulate -> MUL
- DIV: operands are converted to magnitudes for signed ops. Each cycle does one restoring step: shift partial remainder left with the next dividend bit, subtract the divisor, keep the result if non-negative, set the quotient bit. A counter of width $clog2(WIDTH)+1 runs WIDTH cycles, then the state goes to DONE. On entry to DONE, signed results are fixed up:
  - quotient is negated if the operand signs differ
  - remainder takes the sign of the dividend
- Divide by zero: lo_o = all ones, hi_o = opa_i, div_zero_o = 1.
- MUL: the full 2*WIDTH product is registered. Signed ops multiply magnitudes and negate the product if the signs differ. MULT/MULTU go to DONE; accumulate ops go to ACC.
- ACC: samples hilo_i in this cycle, so it gets the freshest forwarded value. MADD/MADDU: hilo_i + product. MSUB/MSUBU: hilo_i − product. Both are modulo 2^(2*WIDTH), with no overflow flag. Then -> DONE.
- DONE: done_o = 1; hi_o/lo_o/div_zero_o hold. Stays in DONE while start_i is high; goes to IDLE when start_i is low. This gives exactly one HI/LO write per instruction, even if EX is held by another stall.
- cancel_i in any state: next state IDLE, no done_o pulse, partial results discarded.
- Unused op codes: treated as MULTU.

## Timing
- busy_o = !cancel_i & ((IDLE & start_i) | DIV | MUL | ACC). It is combinational, so the stall is raised in the same cycle the instruction reaches EX. busy_o is 0 in DONE.
- Acceptance cycle 0 (IDLE). done_o first high in:
  - cycle 2 for MULT
  - cycle 3 for MADD/MSUB
  - cycle WIDTH+1 for DIV
  - cycle 1 for divide-by-zero
- Outputs are registered. hi_o/lo_o/div_zero_o change only on entry to DONE and are zero otherwise.
- Reset: state IDLE, counter 0; busy_o, done_o, div_zero_o, hi_o, lo_o all 0.
- rst wins over cancel_i; cancel_i wins over start_i.

## Configuration
- MULDIV_MADD_EN defined: MADD/MADDU/MSUB/MSUBU are supported; ACC state and hilo_i adder/subtractor are present.
- Not defined: ACC state, adder and hilo_i usage are removed. Accumulate op codes behave as MULT/MULTU of the same signedness (2-cycle latency), and hilo_i is ignored.

## Structure
- muldiv_pkg holds:
  - op_i encodings (MD_DIV … MD_MSUBU)
  - state enum
  - result fill constant for divide-by-zero
- Sub-module div_step is combinational: one restoring iteration, taking partial remainder, divisor and quotient and returning their next values. It is instantiated once inside muldiv_unit.
- Sign conversion and negation are shared between the divide and multiply paths.

## Test plan
- DIV, WIDTH=32, opa=-7, opb=2 -> done_o at cycle 33, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, busy_o high cycles 0–32.
- DIVU, opa=0xFFFFFFFF, opb=0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF; DIV with opb=0, opa=5 -> cycle 1 done_o, div_zero_o=1, lo_o=0xFFFFFFFF, hi_o=5.
- MULT, opa=-3, opb=4 -> cycle 2 done_o, {hi,lo}=0xFFFFFFFF_FFFFFFF4; MULTU, opa=opb=0xFFFFFFFF -> 0xFFFFFFFE_00000001.
- MADD (MULDIV_MADD_EN), hilo_i=0x1_00000000, opa=2, opb=3 -> cycle 3, {hi,lo}=0x1_00000006. MSUB with hilo_i=0, opa=1, opb=1 -> all ones. Without the macro the same MADD gives 6 at cycle 2.
- DIV in progress, cancel_i at cycle 10 -> IDLE at cycle 11, no done_o. New MULT starting at cycle 11 completes normally. rst at cycle 5 of a DIV -> all outputs 0 next cycle.
- start_i held 5 cycles past DONE -> done_o held, one logical write, no restart. start_i drops -> IDLE, and a back-to-back new start is accepted next cycle.
